usb_rx_packet_buffer: RTL
=========================

USB_RX_PACKET_BUFFER -- requirements
Module: usb_rx_packet_buffer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: n_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: rx_packet  input  3  packet-type event from usb_rx; non-NONE for exactly one cycle at packet end.
REQ-004 SHALL have port: rx_packet_data  input  8  received payload byte, valid when store_rx_packet_data=1.
REQ-005 SHALL have port: store_rx_packet_data  input  1  one-cycle push strobe for rx_packet_data.
REQ-006 SHALL have port: get_rx_data  input  1  one-cycle pop strobe from the AHB side.
REQ-007 SHALL have port: flush  input  1  clear buffer and error state.
REQ-008 SHALL have port: rx_data  output  8  head-of-FIFO byte (first-word fall-through); 8'h00 when empty.
REQ-009 SHALL have port: buffer_occupancy  output  7  stored byte count, 0..64.
REQ-010 SHALL have port: rx_data_ready  output  1  high in state READY.
REQ-011 SHALL have port: rx_transfer_active  output  1  high in state RCV.
REQ-012 SHALL have port: rx_error  output  1  high in state ERR.
REQ-013 SHALL have port: overflow  output  1  sticky, set when a push is dropped.
REQ-014 SHALL have port: last_packet  output  3  most recent non-NONE rx_packet value.

Function
REQ-015 SHALL decode rx_packet as: 0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 ERROR.
REQ-016 SHALL implement a 64-entry x 8-bit circular FIFO with 6-bit read/write pointers wrapping 63->0.
REQ-017 SHALL accept a push only in IDLE or RCV with occupancy<64; any other push is dropped and sets overflow.
REQ-018 SHALL perform a pop only when occupancy>0; pop when empty is ignored, no state change.
REQ-019 SHALL, on simultaneous accepted push and pop, advance both pointers and leave occupancy unchanged; on push+pop while empty, accept the push only.
REQ-020 SHALL update buffer_occupancy and rx_data in the cycle after the causing strobe (one-cycle latency).
REQ-021 SHALL implement FSM states IDLE, RCV, READY, ERR.
REQ-022 SHALL transition IDLE->RCV on an accepted push.
REQ-023 SHALL transition IDLE or RCV ->READY on rx_packet DATA0/DATA1 when overflow=0.
REQ-024 SHALL transition IDLE or RCV ->ERR on rx_packet ERROR, or on DATA0/DATA1 when overflow=1.
REQ-025 SHALL transition RCV->ERR on rx_packet OUT, IN, ACK or NAK (token inside payload).
REQ-026 SHALL, in IDLE, on OUT/IN/ACK/NAK update last_packet only, remaining in IDLE.
REQ-027 SHALL transition READY->IDLE on the first cycle in READY with occupancy=0, so a zero-length DATA packet shows rx_data_ready for exactly one cycle.
REQ-028 SHALL stay in ERR until flush; pops in ERR remain legal.
REQ-029 SHALL, on flush, zero pointers, occupancy and overflow and enter IDLE next cycle, with priority over same-cycle push, pop and rx_packet; last_packet is retained.
REQ-030 SHALL capture last_packet on every non-NONE rx_packet cycle, including in READY and ERR.
REQ-031 SHALL ignore rx_packet events in READY (except last_packet capture).

Reset
REQ-032 SHALL, on n_rst=0, asynchronously set state IDLE, pointers 0, buffer_occupancy 0, rx_data 8'h00, overflow 0, last_packet NONE, all status outputs 0.
REQ-033 SHALL, on reset mid-packet, discard all stored bytes; FIFO memory contents need not be cleared.

Structure
REQ-034 SHALL take the rx_packet encoding enum and RX_FIFO_DEPTH=64 from shared package usb_pkg, also used by usb_rx.
REQ-035 SHALL place storage in a single sub-module usb_rx_fifo_ram (64x8, synchronous write, asynchronous read); FSM and pointers in the top.

Verification
REQ-036 SHALL cover: push 8'hA5,8'h3C then DATA0 -> READY, occupancy=2, rx_data=8'hA5; two pops -> rx_data 8'h3C then IDLE, occupancy 0.
REQ-037 SHALL cover: 65 pushes then DATA1 -> occupancy=64, overflow=1, ERR; flush -> IDLE, occupancy 0, overflow 0.
REQ-038 SHALL cover: 64 push/pop pairs across pointer wrap at occupancy 1 -> occupancy stays 1, data order preserved.
REQ-039 SHALL cover: DATA0 with no pushes in IDLE -> rx_data_ready high exactly one cycle, last_packet=3.
REQ-040 SHALL cover: n_rst asserted in RCV with occupancy 5 -> immediate IDLE, occupancy 0, rx_data 8'h00.
REQ-041 SHALL cover: flush, push and pop in same cycle at occupancy 3 -> occupancy 0, IDLE.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB receive-path types and sizes.
// Used by usb_rx and the receive packet buffer.
package usb_pkg;

  localparam int RX_FIFO_DEPTH = 64;
  localparam int PTR_W = 6;
  localparam int OCC_W = 7;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_OUT   = 3'd1,
    PKT_IN    = 3'd2,
    PKT_DATA0 = 3'd3,
    PKT_DATA1 = 3'd4,
    PKT_ACK   = 3'd5,
    PKT_NAK   = 3'd6,
    PKT_ERROR = 3'd7
  } rx_pkt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RCV,
    ST_READY,
    ST_ERR
  } rx_state_e;

  function automatic logic is_data(rx_pkt_e p);
    return (p == PKT_DATA0) || (p == PKT_DATA1);
  endfunction

  function automatic logic is_token(rx_pkt_e p);
    return (p == PKT_OUT) || (p == PKT_IN) ||
           (p == PKT_ACK) || (p == PKT_NAK);
  endfunction

endpackage

// File: rtl/usb_rx_fifo_ram.sv
// 64x8 receive storage: synchronous write,
// asynchronous read.
module usb_rx_fifo_ram
  import usb_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [RX_FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// USB receive packet buffer: FIFO pointers,
// occupancy and packet-state FSM.
module usb_rx_packet_buffer
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic [7:0] rx_packet_data,
  input  logic       store_rx_packet_data,
  input  logic       get_rx_data,
  input  logic       flush,
  output logic [7:0] rx_data,
  output logic [6:0] buffer_occupancy,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       overflow,
  output logic [2:0] last_packet
);

  localparam logic [OCC_W-1:0] FULL =
    OCC_W'(RX_FIFO_DEPTH);

  rx_state_e        state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  rx_pkt_e          last_q, last_d;

  rx_pkt_e    pkt;
  logic       push_ok;
  logic       pop_ok;
  logic [7:0] ram_rdata;

  assign pkt = rx_pkt_e'(rx_packet);

  assign push_ok = store_rx_packet_data &&
                   (state_q == ST_IDLE ||
                    state_q == ST_RCV) &&
                   (occ_q != FULL);
  assign pop_ok  = get_rx_data && (occ_q != '0);

  usb_rx_fifo_ram u_ram (
    .clk   (clk),
    .we    (push_ok && !flush),
    .waddr (wptr_q),
    .wdata (rx_packet_data),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    last_d = last_q;
    if (pkt != PKT_NONE) last_d = pkt;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      if (push_ok && !pop_ok) occ_d = occ_q + 1'b1;
      if (pop_ok && !push_ok) occ_d = occ_q - 1'b1;
      if (store_rx_packet_data && !push_ok)
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      last_q <= PKT_NONE;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Packet events take priority over a same-cycle push.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_data(pkt))
            state_d = ovf_q ? ST_ERR : ST_READY;
          else if (pkt == PKT_ERROR)
            state_d = ST_ERR;
          else if (push_ok)
            state_d = ST_RCV;
        end
        ST_RCV: begin
          if (is_data(pkt))
            state_d = ovf_q ? ST_ERR : ST_READY;
          else if (pkt == PKT_ERROR || is_token(pkt))
            state_d = ST_ERR;
        end
        ST_READY: begin
          if (occ_q == '0) state_d = ST_IDLE;
        end
        ST_ERR: state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_data_ready      = 1'b0;
    rx_transfer_active = 1'b0;
    rx_error           = 1'b0;
    unique case (state_q)
      ST_READY: rx_data_ready      = 1'b1;
      ST_RCV:   rx_transfer_active = 1'b1;
      ST_ERR:   rx_error           = 1'b1;
      default:  ;
    endcase
  end

  assign rx_data          = (occ_q == '0) ? 8'h00 : ram_rdata;
  assign buffer_occupancy = occ_q;
  assign overflow         = ovf_q;
  assign last_packet      = last_q;

endmodule
